pwm_dac: RTL and testbench

- Bus-attached 1-bit DAC stage directly downstream of the sawtooth/waveform generators.
- Consumes their 8-bit sample bus and drives one output pin.
- Two modes: PWM, with the sample double-buffered per period, and first-order sigma-delta.
- Configured through the same valid/ready/wstrb CSR bus as its neighbours.

---
 rtl/dac_pkg.sv | 31 +++
 rtl/dac_prescaler.sv | 32 +++
 rtl/pwm_dac.sv | 165 ++++++++++++++++
 tb/tb_pwm_dac.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the pwm_dac block: register indices, CTRL bit
// positions, modulator mode encoding and the byte-strobe merge helper.
package dac_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_INV  = 2;
  localparam int CTRL_W    = 3;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_SD  = 1'b1
  } mode_t;

  // Replace only the bytes whose write strobe is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dac_prescaler.sv
// Tick generator: counts 0..limit and asserts tick in the cycle the count
// equals limit, then wraps. clear forces the count to 0 and suppresses tick.
module dac_prescaler
  import dac_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         tick
);

  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count and tick; a tick or a clear restarts the count at 0.
  always_comb begin
    tick  = !clear && (cnt_q == limit);
    cnt_d = cnt_q + CNT_ONE;
    if (clear || tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_dac.sv
// 1-bit DAC output stage: CSR decode, double-buffered PWM modulator and
// first-order sigma-delta modulator sharing one prescaler tick.
module pwm_dac
  import dac_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int SAMPLE_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  output logic                ready,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic [SAMPLE_W-1:0] in,
  output logic                dac_out,
  output logic                period_start
);

  localparam logic [SAMPLE_W-1:0] CNT_ONE = SAMPLE_W'(1);

  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [SAMPLE_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [SAMPLE_W-1:0]   shadow_q, shadow_d;
  logic [SAMPLE_W:0]     acc_q, acc_d;
  logic                  dac_q, dac_d;
  logic                  ps_q, ps_d;
  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [1:0]            reg_idx;
  logic                  wr_en;
  logic                  csr_wr;
  logic                  enable;
  logic                  invert;
  mode_t                 mode;
  logic                  tick;
  logic                  pre_clear;
  logic [31:0]           cur_val;
  logic [31:0]           wr_val;
  logic [31:0]           rd_val;
  logic [SAMPLE_W-1:0]   cnt_nxt;
  logic [SAMPLE_W-1:0]   shadow_nxt;
  logic [SAMPLE_W:0]     acc_sum;

  // Bits of the bus that carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wr_val[31:PRESCALE_W], acc_q[SAMPLE_W]};

  // CSR decode: register writes with byte strobes, read mux, bus handshake.
  always_comb begin
    reg_idx = addr[3:2];
    wr_en   = valid && (wstrb != 4'b0000);
    csr_wr  = wr_en && ((reg_idx == ADDR_CTRL) || (reg_idx == ADDR_PRESCALE));
    enable  = ctrl_q[CTRL_EN];
    invert  = ctrl_q[CTRL_INV];
    mode    = mode_t'(ctrl_q[CTRL_MODE]);

    case (reg_idx)
      ADDR_CTRL:     rd_val = 32'(ctrl_q);
      ADDR_PRESCALE: rd_val = 32'(prescale_q);
      ADDR_STATUS:   rd_val = 32'(shadow_q) | (32'(pwm_cnt_q) << 8) | (32'(dac_q) << 16);
      default:       rd_val = 32'h0;
    endcase

    cur_val = (reg_idx == ADDR_CTRL) ? 32'(ctrl_q) : 32'(prescale_q);
    wr_val  = apply_wstrb(cur_val, wdata, wstrb);

    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    if (wr_en && (reg_idx == ADDR_CTRL))     ctrl_d     = wr_val[CTRL_W-1:0];
    if (wr_en && (reg_idx == ADDR_PRESCALE)) prescale_d = wr_val[PRESCALE_W-1:0];

    ready_d = valid;
    rdata_d = valid ? rd_val : rdata_q;
  end

  // The prescaler restarts on any configuration change and idles while disabled.
  assign pre_clear = csr_wr || !enable;

  dac_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (pre_clear),
    .limit (prescale_q),
    .tick  (tick)
  );

  // Modulators: state advances only on tick; config writes and disable zero it.
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q;
    shadow_d   = shadow_q;
    acc_d      = acc_q;
    dac_d      = dac_q;
    ps_d       = 1'b0;
    cnt_nxt    = pwm_cnt_q + CNT_ONE;
    shadow_nxt = shadow_q;
    acc_sum    = {1'b0, acc_q[SAMPLE_W-1:0]} + {1'b0, in};

    if (csr_wr || !enable) begin
      pwm_cnt_d = '0;
      shadow_d  = '0;
      acc_d     = '0;
      dac_d     = 1'b0;
    end else if (tick) begin
      case (mode)
        MODE_PWM: begin
          // The sample is latched only at the period boundary so that a
          // mid-period change on `in` cannot distort the running period.
          if (cnt_nxt == '0) begin
            shadow_nxt = in;
            ps_d       = 1'b1;
          end
          pwm_cnt_d = cnt_nxt;
          shadow_d  = shadow_nxt;
          dac_d     = (cnt_nxt < shadow_nxt) ^ invert;
        end
        MODE_SD: begin
          // Carry out of the sample-width accumulator is the 1-bit output.
          acc_d    = acc_sum;
          shadow_d = in;
          dac_d    = acc_sum[SAMPLE_W] ^ invert;
          ps_d     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      pwm_cnt_q  <= '0;
      shadow_q   <= '0;
      acc_q      <= '0;
      dac_q      <= 1'b0;
      ps_q       <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pwm_cnt_q  <= pwm_cnt_d;
      shadow_q   <= shadow_d;
      acc_q      <= acc_d;
      dac_q      <= dac_d;
      ps_q       <= ps_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ready        = ready_q;
  assign rdata        = rdata_q;
  assign dac_out      = dac_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: directed and randomized steps checked every cycle
// against a tick-counting arithmetic model of the DAC.
module tb_pwm_dac;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sample;
  logic        dac_out;
  logic        period_start;

  int checks = 0;
  int errors = 0;

  // Model state: configuration plus counts of edges/ticks since last restart.
  logic [2:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [7:0]  m_cnt;
  logic [7:0]  m_shadow;
  logic        m_dac;
  logic        m_ps;
  logic        m_ready;
  logic [31:0] m_rdata;
  longint      m_edges;
  longint      m_ticks;
  longint      m_sum;

  pwm_dac #(
    .PRESCALE_W (16),
    .SAMPLE_W   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .ready        (ready),
    .wstrb        (wstrb),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .in           (sample),
    .dac_out      (dac_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    m_edges  = 0;
    m_ticks  = 0;
    m_sum    = 0;
    m_cnt    = 8'd0;
    m_shadow = 8'd0;
    m_dac    = 1'b0;
    m_ps     = 1'b0;
  endtask

  // One clock: predict the effect of the inputs present at this edge, then
  // compare all outputs just after the edge.
  task automatic step();
    logic        r_s, v_s;
    logic [3:0]  s_s;
    logic [1:0]  a_s;
    logic [31:0] w_s, rd_m, merged;
    logic [7:0]  in_s;
    longint      prev;
    r_s  = reset;
    v_s  = valid;
    s_s  = wstrb;
    a_s  = addr[3:2];
    w_s  = wdata;
    in_s = sample;
    case (a_s)
      2'd0:    rd_m = {29'd0, m_ctrl};
      2'd1:    rd_m = {16'd0, m_pre};
      2'd2:    rd_m = {15'd0, m_dac, m_cnt, m_shadow};
      default: rd_m = 32'd0;
    endcase
    @(posedge clk);
    if (r_s) begin
      m_ctrl  = 3'd0;
      m_pre   = 16'd0;
      m_ready = 1'b0;
      m_rdata = 32'd0;
      clear_model();
    end else begin
      m_ready = v_s;
      if (v_s) m_rdata = rd_m;
      if (v_s && (s_s != 4'd0) && (a_s <= 2'd1)) begin
        merged = (a_s == 2'd0) ? {29'd0, m_ctrl} : {16'd0, m_pre};
        for (int i = 0; i < 4; i++) if (s_s[i]) merged[8*i +: 8] = w_s[8*i +: 8];
        if (a_s == 2'd0) m_ctrl = merged[2:0];
        else             m_pre  = merged[15:0];
        clear_model();
      end else if (!m_ctrl[0]) begin
        clear_model();
      end else begin
        m_edges++;
        m_ps = 1'b0;
        if (m_edges % (longint'(m_pre) + 1) == 0) begin
          m_ticks++;
          if (!m_ctrl[1]) begin
            m_cnt = 8'(m_ticks % 256);
            if (m_cnt == 8'd0) begin
              m_shadow = in_s;
              m_ps     = 1'b1;
            end
            m_dac = (m_cnt < m_shadow) ^ m_ctrl[2];
          end else begin
            prev     = m_sum / 256;
            m_sum    = m_sum + longint'(in_s);
            m_dac    = ((m_sum / 256) != prev) ^ m_ctrl[2];
            m_shadow = in_s;
            m_ps     = 1'b1;
          end
        end
      end
    end
    #1;
    chk("dac_out", {31'd0, dac_out}, {31'd0, m_dac});
    chk("period_start", {31'd0, period_start}, {31'd0, m_ps});
    chk("ready", {31'd0, ready}, {31'd0, m_ready});
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic bus_write(input logic [1:0] idx, input logic [31:0] data, input logic [3:0] strb);
    valid = 1'b1;
    addr  = {28'd0, idx, 2'b00};
    wdata = data;
    wstrb = strb;
    step();
    valid = 1'b0;
    wstrb = 4'd0;
  endtask

  task automatic bus_read(input logic [1:0] idx);
    valid = 1'b1;
    addr  = {28'd0, idx, 2'b00};
    wstrb = 4'd0;
    step();
    valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_count(input int n, output int hi, output int ps);
    hi = 0;
    ps = 0;
    for (int i = 0; i < n; i++) begin
      step();
      hi += int'(dac_out);
      ps += int'(period_start);
    end
  endtask

  initial begin
    int hi, ps, hi0, hi1, hi2, ps1;
    logic [2:0] rc;
    logic [1:0] ra;
    reset  = 1'b1;
    valid  = 1'b0;
    wstrb  = 4'd0;
    addr   = 32'd0;
    wdata  = 32'd0;
    sample = 8'd0;
    m_ctrl = 3'd0;
    m_pre  = 16'd0;
    m_ready = 1'b0;
    m_rdata = 32'd0;
    clear_model();

    // Reset and bus read-back.
    run(3);
    reset = 1'b0;
    bus_read(2'd2);
    chk("rst_status", rdata, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    bus_read(2'd0);
    chk("rst_ctrl", rdata, 32'd0);
    chk("rst_dac", {31'd0, dac_out}, 32'd0);
    step();
    chk("ready_drop", {31'd0, ready}, 32'd0);

    // PWM at 25 % duty.
    sample = 8'd64;
    bus_write(2'd1, 32'd0, 4'hF);
    bus_write(2'd0, 32'h1, 4'hF);
    run(255);
    run_count(256, hi, ps);
    chk("pwm25_hi", hi, 64);
    chk("pwm25_ps", ps, 1);
    bus_read(2'd2);
    chk("pwm25_shadow", {24'd0, rdata[7:0]}, 32'd64);
    hi0 = int'(dac_out);

    // Double buffering: change the sample at pwm_cnt = 100.
    run_count(100, hi1, ps);
    sample = 8'd192;
    run_count(155, hi2, ps);
    chk("dbuf_cur", hi0 + hi1 + hi2, 64);
    run_count(256, hi, ps);
    chk("dbuf_next", hi, 192);

    // Prescale by 4 with inverted output.
    bus_write(2'd1, 32'd3, 4'hF);
    bus_write(2'd0, 32'h5, 4'hF);
    sample = 8'd128;
    run(1023);
    run_count(1024, hi, ps);
    chk("pre_inv_hi", hi, 512);
    chk("pre_inv_ps", ps, 1);

    // Partial byte strobe on PRESCALE, upper bits of the word ignored.
    bus_write(2'd1, 32'hFFFF_0500, 4'b0010);
    bus_read(2'd1);
    chk("strobe_pre", rdata, 32'h0000_0503);

    // Sigma-delta densities.
    bus_write(2'd1, 32'd0, 4'hF);
    bus_write(2'd0, 32'h3, 4'hF);
    sample = 8'd85;
    run_count(256, hi, ps);
    chk("sd85_hi", hi, 85);
    chk("sd85_ps", ps, 256);
    sample = 8'd0;
    run_count(256, hi, ps);
    chk("sd0_hi", hi, 0);
    sample = 8'd255;
    run_count(256, hi, ps);
    chk("sd255_hi", hi, 255);

    // PRESCALE write mid-period clears the PWM state.
    bus_write(2'd0, 32'h1, 4'h1);
    sample = 8'd77;
    run(300);
    chk("mid_dac_before", {31'd0, dac_out}, 32'd1);
    bus_write(2'd1, 32'd0, 4'h3);
    chk("mid_dac_after", {31'd0, dac_out}, 32'd0);
    bus_read(2'd2);
    chk("mid_status_cnt", {15'd0, rdata[16:8]}, 32'd0);

    // Disabled with invert set.
    bus_write(2'd0, 32'h4, 4'h1);
    run_count(40, hi, ps);
    chk("dis_hi", hi, 0);
    chk("dis_ps", ps, 0);

    // Reset mid-period.
    bus_write(2'd0, 32'h1, 4'h1);
    sample = 8'd200;
    run(300);
    reset = 1'b1;
    valid = 1'b1;
    addr  = 32'h8;
    step();
    reset = 1'b0;
    valid = 1'b0;
    chk("mrst_dac", {31'd0, dac_out}, 32'd0);
    chk("mrst_ready", {31'd0, ready}, 32'd0);
    chk("mrst_rdata", rdata, 32'd0);
    bus_read(2'd0);
    chk("mrst_ctrl", rdata, 32'd0);

    // Randomized configurations, samples and register reads.
    for (int it = 0; it < 8; it++) begin
      bus_write(2'd1, ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 2)), 4'hF);
      rc = 3'($urandom_range(0, 7));
      if (it < 6) rc[0] = 1'b1;
      bus_write(2'd0, ($urandom & 32'hFFFF_FFF8) | 32'(rc), 4'h1);
      for (int j = 0; j < 350; j++) begin
        if ($urandom_range(0, 6) == 0) sample = 8'($urandom);
        if ($urandom_range(0, 11) == 0) begin
          ra    = 2'($urandom_range(0, 3));
          valid = 1'b1;
          addr  = {28'd0, ra, 2'b00};
          wstrb = 4'd0;
        end else begin
          valid = 1'b0;
        end
        step();
      end
      valid = 1'b0;
    end
    run_count(2, hi, ps1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
